// File: rtl/ei_axi4_wbeat_generator.sv
// AXI4 write-data beat generator: takes one AW-style burst command plus a raw data
// stream and drives the W channel beat by beat with per-beat strobes, address and WLAST.
module ei_axi4_wbeat_generator #(
  parameter int BUS_BYTE_LANES = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 8 * BUS_BYTE_LANES
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [1:0]                cmd_burst,
  input  logic [2:0]                cmd_size,
  input  logic [7:0]                cmd_len,
  input  logic                      din_valid,
  output logic                      din_ready,
  input  logic [DATA_WIDTH-1:0]     din_data,
  output logic                      wvalid,
  input  logic                      wready,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [BUS_BYTE_LANES-1:0] wstrb,
  output logic                      wlast,
  output logic [ADDR_WIDTH-1:0]     beat_addr,
  output logic                      burst_done,
  output logic                      cmd_err
);

  typedef enum logic {IDLE, BURST} state_e;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [2:0] MAX_SIZE    = 3'($clog2(BUS_BYTE_LANES));
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(BUS_BYTE_LANES - 1);

  state_e                    state_q, state_d;
  logic [1:0]                burst_q;
  logic [2:0]                size_q;
  logic [7:0]                len_q;
  logic [8:0]                issued_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [ADDR_WIDTH-1:0]     wrap_lower_q, wrap_upper_q;
  logic                      wvalid_q, wlast_q, cmd_err_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [BUS_BYTE_LANES-1:0] wstrb_q;
  logic [ADDR_WIDTH-1:0]     beat_addr_q;

  logic cmd_hs, din_hs, cmd_legal;

  // Command legality and wrap boundaries, evaluated on the raw command inputs.
  logic [ADDR_WIDTH-1:0] cmd_bytes, span_bytes, cmd_aligned, cmd_last_byte;
  logic [ADDR_WIDTH-1:0] wrap_lower_d, wrap_upper_d;

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    cmd_bytes     = ADDR_WIDTH'(1) << cmd_size;
    span_bytes    = (ADDR_WIDTH'(cmd_len) + ADDR_WIDTH'(1)) << cmd_size;
    cmd_aligned   = cmd_addr & ~(cmd_bytes - ADDR_WIDTH'(1));
    cmd_last_byte = cmd_aligned + span_bytes - ADDR_WIDTH'(1);
    wrap_lower_d  = cmd_addr & ~(span_bytes - ADDR_WIDTH'(1));
    wrap_upper_d  = wrap_lower_d + span_bytes;
    cmd_legal     = (cmd_size <= MAX_SIZE);
    case (cmd_burst)
      BURST_FIXED: if (cmd_len > 8'd15) cmd_legal = 1'b0;
      BURST_INCR:  if ((cmd_addr >> 12) != (cmd_last_byte >> 12)) cmd_legal = 1'b0;
      BURST_WRAP: begin
        if (!(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15})) cmd_legal = 1'b0;
        if ((cmd_addr & (cmd_bytes - ADDR_WIDTH'(1))) != '0) cmd_legal = 1'b0;
      end
      default:     cmd_legal = 1'b0;
    endcase
  end

  // Address step and strobe for the beat that the next din handshake will load.
  logic [ADDR_WIDTH-1:0]     bytes, aligned, incr_addr, next_addr, lane_lo, lane_hi;
  logic [BUS_BYTE_LANES-1:0] beat_strb;

  always_comb begin
    bytes     = ADDR_WIDTH'(1) << size_q;
    aligned   = addr_q & ~(bytes - ADDR_WIDTH'(1));
    incr_addr = aligned + bytes;
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_WRAP:  next_addr = (incr_addr == wrap_upper_q) ? wrap_lower_q : incr_addr;
      default:     next_addr = incr_addr;
    endcase
    lane_lo = addr_q & LANE_MASK;
    lane_hi = (aligned & LANE_MASK) + bytes - ADDR_WIDTH'(1);
    for (int i = 0; i < BUS_BYTE_LANES; i++) begin
      beat_strb[i] = (ADDR_WIDTH'(i) >= lane_lo) && (ADDR_WIDTH'(i) <= lane_hi);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    din_ready  = 1'b0;
    burst_done = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = !areset;
        if (cmd_valid && cmd_ready && cmd_legal) state_d = BURST;
      end
      BURST: begin
        din_ready  = (issued_q <= {1'b0, len_q}) && (!wvalid_q || wready);
        burst_done = wvalid_q && wready && wlast_q;
        if (burst_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_hs = cmd_valid && cmd_ready;
  assign din_hs = din_valid && din_ready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      burst_q      <= '0;
      size_q       <= '0;
      len_q        <= '0;
      issued_q     <= '0;
      addr_q       <= '0;
      wrap_lower_q <= '0;
      wrap_upper_q <= '0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      cmd_err_q    <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      beat_addr_q  <= '0;
    end else begin
      cmd_err_q <= cmd_hs && !cmd_legal;
      if (cmd_hs && cmd_legal) begin
        burst_q      <= cmd_burst;
        size_q       <= cmd_size;
        len_q        <= cmd_len;
        addr_q       <= cmd_addr;
        issued_q     <= '0;
        wrap_lower_q <= wrap_lower_d;
        wrap_upper_q <= wrap_upper_d;
      end
      // A new load overrides the drain, which is what gives one beat per cycle.
      if (din_hs) begin
        wdata_q     <= din_data;
        wstrb_q     <= beat_strb;
        beat_addr_q <= addr_q;
        wlast_q     <= (issued_q == {1'b0, len_q});
        wvalid_q    <= 1'b1;
        issued_q    <= issued_q + 9'd1;
        addr_q      <= next_addr;
      end else if (wvalid_q && wready) begin
        wvalid_q <= 1'b0;
        wlast_q  <= 1'b0;
      end
    end
  end

  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wlast     = wlast_q;
  assign beat_addr = beat_addr_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: doc/ei_axi4_wbeat_generator.md
Name: ei_axi4_wbeat_generator

Overview:
- Write-data beat generator for the AXI4 master path.
- Accepts one write-address command (addr/burst/size/len) and a stream of raw data words, then drives the W channel for that burst.
- Per beat it drives WDATA, the byte-lane WSTRB for that beat's address, the beat address and WLAST, with full VALID/READY handshaking.
- Sits between the master's data source and the AXI W-channel pins, downstream of AW command generation.

Parameters:
- BUS_BYTE_LANES, 4, data-bus width in bytes; power of 2, range 1..128.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 8*BUS_BYTE_LANES, W data width.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_addr  in  ADDR_WIDTH  burst start address.
- cmd_burst  in  2  0=FIXED, 1=INCR, 2=WRAP, 3=reserved.
- cmd_size  in  3  bytes per beat = 2**cmd_size.
- cmd_len  in  8  beats = cmd_len+1.
- din_valid  in  1  source data valid.
- din_ready  out  1  source data accepted on din_valid && din_ready.
- din_data  in  DATA_WIDTH  lane-positioned write data.
- wvalid  out  1  W channel valid.
- wready  in  1  W channel ready.
- wdata  out  DATA_WIDTH  registered data.
- wstrb  out  BUS_BYTE_LANES  byte strobes.
- wlast  out  1  final beat of the burst.
- beat_addr  out  ADDR_WIDTH  address of the current W beat (for scoreboard and checker).
- burst_done  out  1  one-cycle pulse on the final beat handshake.
- cmd_err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset (async assert, sync release):
  - FSM enters IDLE; cmd_ready=0 while areset is high.
  - wvalid, wlast, burst_done, cmd_err, din_ready = 0; wdata, wstrb, beat_addr = 0.
  - Reset mid-burst abandons the burst; no further beats are sent.
- States:
  - IDLE: cmd_ready=1, din_ready=0. Handshake → legality check.
    - Illegal: cmd_err=1 on the next cycle; stay in IDLE.
    - Legal: go to BURST with cur_addr=cmd_addr, issued=0, and the command fields latched.
  - BURST: cmd_ready=0. After the wlast handshake, burst_done=1 and return to IDLE; the next command can be accepted the following cycle.
- Illegal commands:
  - 2**cmd_size > BUS_BYTE_LANES.
  - cmd_burst=3.
  - WRAP with cmd_len not in {1,3,7,15}, or cmd_addr not size-aligned.
  - FIXED with cmd_len > 15.
  - INCR where start and last byte lie in different 4 KB pages.
- Output register (single entry, 1-cycle latency din→W):
  - din_ready = BURST && issued <= cmd_len && (!wvalid || wready).
  - On a din handshake, load wdata=din_data, wstrb, beat_addr=cur_addr, and wlast=(issued==cmd_len); then set wvalid=1, increment issued and advance cur_addr.
  - If wvalid && wready with no new load, clear wvalid.
  - While wvalid && !wready, wdata, wstrb, wlast and beat_addr hold stable.
  - Back-to-back beats at 1 beat per cycle are supported.
- Address arithmetic:
  - bytes = 2**size.
  - aligned = cur_addr with its low `size` bits cleared.
  - INCR next = aligned + bytes.
  - FIXED next = cur_addr.
  - WRAP: lower = cmd_addr with its low log2(bytes*(len+1)) bits cleared; upper = lower + bytes*(len+1); next = aligned + bytes, replaced by lower if it equals upper.
  - All arithmetic is modulo 2**ADDR_WIDTH.
- Strobe:
  - lo = cur_addr mod BUS_BYTE_LANES.
  - hi = (aligned mod BUS_BYTE_LANES) + bytes − 1.
  - wstrb bit i = 1 iff lo <= i <= hi.
  - Consequences: the first INCR beat and every FIXED beat drop the unaligned low bytes; later INCR beats and all WRAP beats are full-size.
- Any din_valid asserted in IDLE is ignored (din_ready=0).
- A cmd_valid arriving while in BURST waits; it is not dropped.

Test Plan (BUS_BYTE_LANES=4):
- INCR addr 0x1001, size 2, len 2 → beats at beat_addr 0x1001/0x1004/0x1008, wstrb 0xE/0xF/0xF, wlast only on beat 3, then burst_done pulse.
- WRAP addr 0x1008, size 2, len 3 → beat_addr 0x1008/0x100C/0x1000/0x1004, wstrb 0xF on all beats.
- FIXED addr 0x2003, size 1, len 1 → two beats, beat_addr 0x2003 on both, wstrb 0x8 on both; INCR addr 0x3002, size 0, len 3 → wstrb 0x4/0x8/0x1/0x2.
- Backpressure: wready low for 3 cycles on beat 2 → wvalid/wdata/wstrb/beat_addr stable and din_ready=0 for those cycles; with din_valid and wready held high, 4 beats complete in 4 consecutive cycles.
- Illegal commands: size 3; WRAP len 2; INCR addr 0x0FFC len 1 size 2 → each gives cmd_err one-cycle pulse, wvalid stays 0 and the FSM stays in IDLE.
- Assert areset during beat 2 of a 4-beat burst → wvalid, wlast and din_ready go 0 immediately; after release, a fresh command completes normally with correct strobes.
